// File: rtl/seq_mult_pkg.sv
// Shared types and elaboration helpers for the iterative multiplier.
// Overflow flag output is enabled by defining SEQ_MULT_OVF_EN.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) r++;
        end
        return r;
    endfunction

    function automatic int iter_count(input int w, input int s);
        return w / s;
    endfunction

    function automatic bit step_legal(input int s);
        return (s == 1) || (s == 2) || (s == 4) || (s == 8) || (s == 16);
    endfunction

    function automatic bit cfg_legal(input int w, input int s);
        return step_legal(s) && (w >= 4) && ((w % 2) == 0) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/seq_mult_step.sv
// One multiply iteration: folds a STEP-bit slice of the multiplier,
// shifted into position, into the running accumulator.
module seq_mult_step #(
    parameter int WIDTH = 32,
    parameter int STEP  = 8,
    parameter int CW    = 2
) (
    input  logic [WIDTH-1:0]   mcand_i,
    input  logic [STEP-1:0]    bits_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [CW-1:0]      idx_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] pp;
    logic [2*WIDTH-1:0] pp_sh;
    int                 shamt;

    always_comb begin
        pp    = (2*WIDTH)'(mcand_i) * (2*WIDTH)'(bits_i);
        shamt = int'(idx_i) * STEP;
        pp_sh = pp << shamt;
        acc_o = acc_i + pp_sh;
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier retiring STEP multiplier bits per cycle.
// Define SEQ_MULT_OVF_EN to add the ovf output (product exceeds WIDTH bits).
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   in1,
    input  logic [WIDTH-1:0]   in2,
    output logic               busy,
    output logic               done,
`ifdef SEQ_MULT_OVF_EN
    output logic               ovf,
`endif
    output logic [2*WIDTH-1:0] out
);

    localparam int N  = iter_count(WIDTH, STEP);
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

    if (!cfg_legal(WIDTH, STEP)) begin : g_cfg_err
        $error("seq_multiplier: illegal WIDTH/STEP combination");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] out_q, out_d;
    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] res;
    logic [WIDTH-1:0]   mag1, mag2;
    logic               take;
`ifdef SEQ_MULT_OVF_EN
    logic               sgn_q, sgn_d;
    logic               ovf_q, ovf_d;
    logic [WIDTH:0]     hi_s;
`endif

    seq_mult_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .CW    (CW)
    ) u_step (
        .mcand_i (mcand_q),
        .bits_i  (mplier_q[STEP-1:0]),
        .acc_i   (acc_q),
        .idx_i   (cnt_q),
        .acc_o   (acc_nx)
    );

    // Signed operands are reduced to magnitudes; the sign is reapplied at the end.
    always_comb begin
        mag1 = (signed_mode && in1[WIDTH-1]) ? (~in1 + WIDTH'(1)) : in1;
        mag2 = (signed_mode && in2[WIDTH-1]) ? (~in2 + WIDTH'(1)) : in2;
        res  = neg_q ? (~acc_nx + (2*WIDTH)'(1)) : acc_nx;
        take = start && (state_q != RUN);
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        out_d    = out_q;
`ifdef SEQ_MULT_OVF_EN
        sgn_d    = sgn_q;
        ovf_d    = ovf_q;
        hi_s     = res[2*WIDTH-1:WIDTH-1];
`endif
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (take) begin
                    state_d  = RUN;
                    mcand_d  = mag1;
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    neg_d    = signed_mode & (in1[WIDTH-1] ^ in2[WIDTH-1]);
`ifdef SEQ_MULT_OVF_EN
                    sgn_d    = signed_mode;
`endif
                end
            end
            RUN: begin
                acc_d    = acc_nx;
                mplier_d = mplier_q >> STEP;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    out_d   = res;
`ifdef SEQ_MULT_OVF_EN
                    ovf_d   = sgn_q ? !((&hi_s) || !(|hi_s))
                                    : (|res[2*WIDTH-1:WIDTH]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            out_q    <= out_d;
        end
    end

`ifdef SEQ_MULT_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sgn_q <= sgn_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign out  = out_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed self-checking bench for seq_multiplier at WIDTH=32, STEP=8.
// Overflow checks are compiled in when SEQ_MULT_OVF_EN is defined.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic        done;
    logic [63:0] out;
`ifdef SEQ_MULT_OVF_EN
    logic        ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(
        .WIDTH (32),
        .STEP  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .in1         (in1),
        .in2         (in2),
        .busy        (busy),
        .done        (done),
`ifdef SEQ_MULT_OVF_EN
        .ovf         (ovf),
`endif
        .out         (out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, then check busy on edges 1-4, done on edge 5, hold on edge 6.
    task automatic run_op(input string tag, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        start       = 1'b1;
        signed_mode = s;
        in1         = a;
        in2         = b;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i == 1) begin
                start       = 1'b0;
                signed_mode = ~s;
                in1         = ~a;
                in2         = ~b;
            end
            chk({tag, ":busy"}, {63'd0, busy}, 64'd1);
            chk({tag, ":nodone"}, {63'd0, done}, 64'd0);
        end
        tick();
        chk({tag, ":done"}, {63'd0, done}, 64'd1);
        chk({tag, ":idlebusy"}, {63'd0, busy}, 64'd0);
        chk({tag, ":out"}, out, exp);
        tick();
        chk({tag, ":pulse"}, {63'd0, done}, 64'd0);
        chk({tag, ":hold"}, out, exp);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        in1         = '0;
        in2         = '0;
        tick();
        tick();
        chk("rst:busy", {63'd0, busy}, 64'd0);
        chk("rst:done", {63'd0, done}, 64'd0);
        chk("rst:out", out, 64'd0);
`ifdef SEQ_MULT_OVF_EN
        chk("rst:ovf", {63'd0, ovf}, 64'd0);
`endif
        rst = 1'b0;
        tick();

        run_op("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("s_m3x7", 1'b1, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("u_m3x7", 1'b0, 32'hFFFF_FFFD, 32'd7, 64'h0000_0006_FFFF_FFEB);
        run_op("s_minsq", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("s_minx1", 1'b1, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        run_op("u_zero", 1'b0, 32'd0, 32'h1234_5678, 64'd0);

        run_op("u_ovf", 1'b0, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
`ifdef SEQ_MULT_OVF_EN
        chk("u_ovf:ovf", {63'd0, ovf}, 64'd1);
`endif
        run_op("s_m1sq", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);
`ifdef SEQ_MULT_OVF_EN
        chk("s_m1sq:ovf", {63'd0, ovf}, 64'd0);
`endif
        run_op("s_ovf", 1'b1, 32'h0001_0000, 32'h0000_8000, 64'h0000_0000_8000_0000);
`ifdef SEQ_MULT_OVF_EN
        chk("s_ovf:ovf", {63'd0, ovf}, 64'd1);
`endif

        // start held high through RUN with other operands, then re-issued in DONE
        start       = 1'b1;
        signed_mode = 1'b0;
        in1         = 32'h1234_5678;
        in2         = 32'h0000_0010;
        tick();
        in1 = 32'd9;
        in2 = 32'd9;
        for (int i = 2; i <= 5; i++) begin
            chk("hs:busy", {63'd0, busy}, 64'd1);
            tick();
        end
        chk("hs:done1", {63'd0, done}, 64'd1);
        chk("hs:out1", out, 64'h0000_0001_2345_6780);
        in1 = 32'd3;
        in2 = 32'd5;
        tick();
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        for (int i = 6; i <= 9; i++) begin
            chk("hs:b2busy", {63'd0, busy}, 64'd1);
            chk("hs:b2nodone", {63'd0, done}, 64'd0);
            chk("hs:b2hold", out, 64'h0000_0001_2345_6780);
            if (i < 9) tick();
        end
        tick();
        chk("hs:done2", {63'd0, done}, 64'd1);
        chk("hs:out2", out, 64'd15);
        tick();

        // asynchronous reset mid-operation
        start       = 1'b1;
        signed_mode = 1'b0;
        in1         = 32'h0000_AAAA;
        in2         = 32'd3;
        tick();
        start = 1'b0;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("ar:busy", {63'd0, busy}, 64'd0);
        chk("ar:done", {63'd0, done}, 64'd0);
        chk("ar:out", out, 64'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ar:nodone", {63'd0, done}, 64'd0);
            chk("ar:idle", {63'd0, busy}, 64'd0);
        end
        run_op("ar:after", 1'b0, 32'd6, 32'd7, 64'd42);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised iterative multiplier. Successor to the fixed 32x32 unsigned multiplier.
- Retires STEP multiplier bits per clock.
- Supports signed and unsigned operands, selectable per operation.
- Uses a start/busy/done handshake and holds the product until the next operation.
- Sits beside the ALU datapath; the multi-cycle controller drives it.

Parameters:
- WIDTH, 32, operand width in bits. Must be even and >= 4.
- STEP, 8, multiplier bits retired per cycle. Legal values are 1, 2, 4, 8 or 16. WIDTH % STEP must equal 0.

Ports:
- clk, in, 1, clock. All state changes on the rising edge.
- rst, in, 1, asynchronous active-high reset.
- start, in, 1, request a new multiply. Sampled only when busy=0.
- signed_mode, in, 1, 1 = two's-complement operands; 0 = unsigned. Sampled with start.
- in1, in, WIDTH, multiplicand. Sampled with start.
- in2, in, WIDTH, multiplier. Sampled with start.
- busy, out, 1, high while an operation is in flight.
- done, out, 1, one-cycle pulse when out becomes valid.
- out, out, 2*WIDTH, product. Held stable from the done cycle until the next accepted start completes.

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; busy=0, done=0, out=0.
  - Accumulator, iteration counter and sign flag cleared.
  - Reset mid-operation abandons the operation silently; no done follows.
- Iteration count: N = WIDTH/STEP. Defaults give N=4.
- States:
  - IDLE:
    - start=1 on edge T captures the operands; goes to RUN; busy=1 from T+1.
    - Signed capture: magnitudes |in1| and |in2| are stored as WIDTH-bit unsigned values, and neg = in1[W-1] ^ in2[W-1]. |-2^(W-1)| = 2^(W-1) fits in WIDTH bits unsigned.
    - Unsigned capture: operands stored as-is, neg=0.
  - RUN: each cycle adds (multiplicand * next STEP LSBs of multiplier) << (k*STEP) into a 2*WIDTH accumulator, for k = 0..N-1. After the N-th RUN cycle, goes to DONE.
  - DONE:
    - out = neg ? (~acc + 1) : acc. Two's-complement negation is truncated to 2*WIDTH.
    - done=1 for exactly this cycle; busy=0.
    - Goes to IDLE, unless start=1, which is accepted exactly as in IDLE (back-to-back issue).
- Latency: start sampled at edge T; done and out valid after edge T+N+1 (defaults: 5 cycles). Throughput is one result per N+1 cycles.
- start while busy=1 (RUN): ignored. The operands in flight are unaffected.
- Accumulator arithmetic is unsigned 2*WIDTH and cannot overflow, since max (2^W-1)^2 < 2^(2W).
- out changes only in the DONE cycle or on reset.
- A zero operand still takes the full N iterations; there is no early termination.

Optional Feature:
- Macro SEQ_MULT_OVF_EN.
- Defined:
  - Adds output port ovf, 1 bit, valid with done and held with out; reset value 0.
  - Unsigned mode: ovf=1 iff out[2W-1:W] != 0.
  - Signed mode: ovf=1 iff out[2W-1:W-1] is not all-zeros and not all-ones, i.e. the product does not fit in WIDTH signed bits.
- Undefined: ovf port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package seq_mult_pkg:
  - State enum {IDLE, RUN, DONE}.
  - Function clog2 for counter width.
  - Localparam derivation N = WIDTH/STEP.
  - Legal-STEP check used by an elaboration-time assertion.
- Sub-module seq_mult_step (combinational): inputs multiplicand (WIDTH), STEP multiplier bits, current accumulator and shift index; output next accumulator. It is instantiated once; the top holds all registers and the FSM.

Test Plan (WIDTH=32, STEP=8):
1. Unsigned, start with in1=in2=0xFFFFFFFF at edge 0 -> busy=1 edges 1-4; done=1 after edge 5 only; out=0xFFFFFFFE00000001.
2. Signed, in1=0xFFFFFFFD (-3), in2=7 -> out=0xFFFFFFFFFFFFFFEB (-21). Same operands unsigned -> out=0x00000006FFFFFFEB.
3. Signed, in1=in2=0x80000000 -> out=0x4000000000000000. Then in1=0x80000000, in2=1 -> out=0xFFFFFFFF80000000.
4. Handshake:
   - start=1 held during RUN with different operands -> ignored; first result is unchanged.
   - start=1 in the DONE cycle with 3*5 -> accepted; next done 5 cycles later with out=15.
   - Prior product stays on out until then.
5. rst pulsed asynchronously (mid-cycle) 2 cycles after start -> busy, done and out drop to 0 immediately; no done pulse follows; a new start afterwards completes normally.
6. SEQ_MULT_OVF_EN:
   - Unsigned 0x00010000*0x00010000 -> ovf=1.
   - Signed 0xFFFFFFFF*0xFFFFFFFF -> out=1, ovf=0.
   - Signed 0x00010000*0x00008000 -> ovf=1.
